// File: rtl/cpu_bus_pkg.sv
// Shared types, default widths and grant encoding for the CPU memory-bus arbiter.
package cpu_bus_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_SEL_W   = DEF_DATA_W / 8;
    localparam int unsigned DEF_TIMEOUT = 255;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        IF_BUS,
        DM_BUS,
        IF_RESP,
        DM_RESP
    } arbState_t;

    // A tie goes to whichever port was not served most recently.
    function automatic logic pickGrant(
        input logic ifReq,
        input logic dmReq,
        input logic lastGrant
    );
        if (ifReq && dmReq) begin
            return (lastGrant == GNT_IF) ? GNT_DM : GNT_IF;
        end
        return dmReq ? GNT_DM : GNT_IF;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Bus-transaction watchdog: counts cycles while enabled and flags expiry on the
// TIMEOUT-th enabled cycle since the last clear.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Count only in the bus state; hold at the limit so the counter never wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared single-port memory bus between instruction fetch and
// data memory, returning one-cycle acks and aborting hung transactions.
module mem_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned SEL_W   = DEF_SEL_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [SEL_W-1:0]  dm_sel,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_req,
    output logic              bus_we,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    arbState_t         state;
    arbState_t         nextState;
    logic              lastGrant;
    logic              nextLastGrant;
    logic              nextBusReq;
    logic              nextBusWe;
    logic [SEL_W-1:0]  nextBusSel;
    logic [ADDR_W-1:0] nextBusAddr;
    logic [DATA_W-1:0] nextBusWdata;
    logic [DATA_W-1:0] nextIfRdata;
    logic [DATA_W-1:0] nextDmRdata;
    logic              nextIfAck;
    logic              nextDmAck;
    logic              nextBusErr;
    logic              wdClear;
    logic              wdEnable;
    logic              wdExpired;

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (wdClear),
        .enable (wdEnable),
        .expired(wdExpired)
    );

    // Next-state and next-output logic; bus fields hold unless a grant is made.
    always_comb begin
        nextState     = state;
        nextLastGrant = lastGrant;
        nextBusReq    = bus_req;
        nextBusWe     = bus_we;
        nextBusSel    = bus_sel;
        nextBusAddr   = bus_addr;
        nextBusWdata  = bus_wdata;
        nextIfRdata   = if_rdata;
        nextDmRdata   = dm_rdata;
        nextIfAck     = 1'b0;
        nextDmAck     = 1'b0;
        nextBusErr    = 1'b0;
        wdClear       = 1'b0;
        wdEnable      = 1'b0;

        unique case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    wdClear    = 1'b1;
                    nextBusReq = 1'b1;
                    if (pickGrant(if_req, dm_req, lastGrant) == GNT_DM) begin
                        nextState    = DM_BUS;
                        nextBusWe    = dm_we;
                        nextBusSel   = dm_sel;
                        nextBusAddr  = dm_addr;
                        nextBusWdata = dm_wdata;
                    end else begin
                        nextState    = IF_BUS;
                        nextBusWe    = 1'b0;
                        nextBusSel   = '1;
                        nextBusAddr  = if_addr;
                        nextBusWdata = '0;
                    end
                end
            end
            IF_BUS: begin
                wdEnable = 1'b1;
                if (bus_ack || wdExpired) begin
                    nextIfRdata   = bus_ack ? bus_rdata : '0;
                    nextBusErr    = !bus_ack;
                    nextBusReq    = 1'b0;
                    nextIfAck     = 1'b1;
                    nextLastGrant = GNT_IF;
                    nextState     = IF_RESP;
                end
            end
            DM_BUS: begin
                wdEnable = 1'b1;
                if (bus_ack || wdExpired) begin
                    // Writes leave the read-data register alone; aborts clear it.
                    if (!bus_ack) begin
                        nextDmRdata = '0;
                    end else if (!bus_we) begin
                        nextDmRdata = bus_rdata;
                    end
                    nextBusErr    = !bus_ack;
                    nextBusReq    = 1'b0;
                    nextDmAck     = 1'b1;
                    nextLastGrant = GNT_DM;
                    nextState     = DM_RESP;
                end
            end
            IF_RESP, DM_RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            lastGrant <= GNT_IF;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_err   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
        end else begin
            state     <= nextState;
            lastGrant <= nextLastGrant;
            bus_req   <= nextBusReq;
            bus_we    <= nextBusWe;
            bus_sel   <= nextBusSel;
            bus_addr  <= nextBusAddr;
            bus_wdata <= nextBusWdata;
            bus_err   <= nextBusErr;
            if_rdata  <= nextIfRdata;
            dm_rdata  <= nextDmRdata;
            if_ack    <= nextIfAck;
            dm_ack    <= nextDmAck;
        end
    end

    assign stall_if  = if_req && !if_ack;
    assign stall_mem = dm_req && !dm_ack;

endmodule
